// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: issues one instruction-memory request at a
// time, buffers {pc, instr} pairs in a circular queue and hands the head to
// the datapath over a valid/ready handshake. Redirect flushes the queue and
// restarts fetch at a new PC.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | queue has no room for another fetch; wait for a slot
// ISSUE  | imem_req pulse for fetch_pc (exactly one cycle)
// WAIT   | request outstanding, response will be queued
// DRAIN  | request outstanding but stale after a redirect; response dropped
module instr_fetch_queue #(
  parameter int DEPTH    = 4,
  parameter int PC_W     = 10,
  parameter int INSTR_W  = 16,
  parameter int RESET_PC = 0
) (
  input  logic               Clk,
  input  logic               Rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PC_W-1:0]    r_fetch_pc;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_count_nxt;
  logic [PC_W-1:0]    r_q_pc    [DEPTH];
  logic [INSTR_W-1:0] r_q_instr [DEPTH];

  logic w_empty;
  logic w_ack_wait;
  logic w_push;
  logic w_pop;
  logic w_room;

  assign w_empty     = (r_count == '0);
  assign instr_valid = ~w_empty;
  assign instr       = w_empty ? '0 : r_q_instr[r_rd_ptr];
  assign instr_pc    = w_empty ? '0 : r_q_pc[r_rd_ptr];

  assign imem_req    = (r_state == S_ISSUE);
  assign imem_addr   = imem_req ? r_fetch_pc : '0;

  // Acks outside WAIT (DRAIN, or stray ones after reset) never reach the queue.
  assign w_ack_wait  = (r_state == S_WAIT) & imem_ack;
  assign w_push      = w_ack_wait & ~redirect;
  assign w_pop       = instr_valid & instr_ready & ~redirect;
  assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_room      = (w_count_nxt < CNT_W'(DEPTH));

  // Next-state logic; a redirect empties the queue so it always leaves room.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (redirect || w_room) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_nxt = redirect ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (imem_ack) begin
          if (redirect || w_room) begin
            w_state_nxt = S_ISSUE;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (redirect) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (imem_ack) begin
          w_state_nxt = S_ISSUE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Fetch PC: redirect wins over the post-ack increment; wraps at 2^PC_W.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_fetch_pc <= PC_W'(RESET_PC);
    end else if (redirect) begin
      r_fetch_pc <= redirect_pc;
    end else if (w_push) begin
      r_fetch_pc <= r_fetch_pc + PC_W'(1);
    end
  end

  // Queue pointers and occupancy; redirect flushes in the same edge.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (redirect) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  // Queue storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge Clk) begin
    if (!Rst && w_push) begin
      r_q_pc[r_wr_ptr]    <= r_fetch_pc;
      r_q_instr[r_wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed scenarios followed by random traffic,
// all checked against a queue-level reference model and a bench-side memory.
module tb_instr_fetch_queue;

  localparam int DEPTH    = 4;
  localparam int PC_W     = 10;
  localparam int INSTR_W  = 16;
  localparam int RESET_PC = 0;

  logic               Clk = 1'b0;
  logic               Rst = 1'b1;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack = 1'b0;
  logic [INSTR_W-1:0] imem_rdata = '0;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    instr_pc;
  logic               instr_ready = 1'b0;
  logic               redirect = 1'b0;
  logic [PC_W-1:0]    redirect_pc = '0;

  always #5 Clk = ~Clk;

  instr_fetch_queue #(
    .DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(RESET_PC)
  ) dut (
    .Clk(Clk), .Rst(Rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] ins;
  } ent_t;

  ent_t mq[$];
  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;

  // bench memory: one outstanding request
  bit                 mem_busy = 0;
  bit                 mem_stale = 0;
  int                 mem_due = 0;
  logic [PC_W-1:0]    mem_addr = '0;
  logic [INSTR_W-1:0] mem_data = '0;
  int                 mem_lat = 1;     // 0 = random 1..4
  int                 data_mode = 0;   // 0: A000|addr, 1: random, 2: data_fix
  logic [INSTR_W-1:0] data_fix = '0;

  logic [PC_W-1:0]    exp_pc = PC_W'(RESET_PC);
  int                 idle_cnt = 0;
  bit                 saw_dead = 0;
  int                 first_valid_cyc = -1;
  logic [INSTR_W-1:0] first_instr = '0;

  int                 req_cyc[$];
  logic [PC_W-1:0]    req_addr[$];
  logic [PC_W-1:0]    pop_log[$];

  bit                 d_rst = 1;
  bit                 d_ready = 0;
  bit                 d_redir = 0;
  logic [PC_W-1:0]    d_rpc = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    logic               s_req, s_valid;
    logic [PC_W-1:0]    s_addr, s_pc;
    logic [INSTR_W-1:0] s_ins;
    bit                 ack;
    ent_t               e;
    @(negedge Clk);
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_valid = instr_valid;
    s_ins   = instr;
    s_pc    = instr_pc;
    ack = mem_busy && (cyc >= mem_due);
    Rst         = d_rst;
    instr_ready = d_ready;
    redirect    = d_redir;
    redirect_pc = d_rpc;
    imem_ack    = ack;
    imem_rdata  = ack ? mem_data : INSTR_W'($urandom);

    chk("instr_valid", 32'(s_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("instr", 32'(s_ins), 32'(mq[0].ins));
      chk("instr_pc", 32'(s_pc), 32'(mq[0].pc));
    end else begin
      chk("instr_empty", 32'(s_ins), 32'd0);
      chk("instr_pc_empty", 32'(s_pc), 32'd0);
    end
    if (s_req) begin
      chk("req_addr", 32'(s_addr), 32'(exp_pc));
      chk("one_outstanding", 32'(mem_busy && !ack), 32'd0);
      chk("req_room", 32'(mq.size() < DEPTH), 32'd1);
    end else begin
      chk("addr_idle", 32'(s_addr), 32'd0);
    end
    if (s_valid && first_valid_cyc < 0) begin
      first_valid_cyc = cyc;
      first_instr     = s_ins;
    end

    if (mq.size() != 0 && d_ready && !d_redir && !d_rst) begin
      pop_log.push_back(s_pc);
      void'(mq.pop_front());
    end
    if (ack) begin
      mem_busy = 0;
      if (!mem_stale && !d_redir && !d_rst) begin
        chk("no_overflow", 32'(mq.size() < DEPTH), 32'd1);
        e.pc  = mem_addr;
        e.ins = mem_data;
        mq.push_back(e);
        exp_pc = mem_addr + PC_W'(1);
        if (mem_data == 16'hDEAD) saw_dead = 1;
      end
    end
    if (s_req) begin
      req_cyc.push_back(cyc);
      req_addr.push_back(s_addr);
      mem_busy  = 1;
      mem_stale = d_redir || d_rst;
      mem_addr  = s_addr;
      mem_due   = cyc + ((mem_lat == 0) ? int'($urandom_range(1, 4)) : mem_lat);
      case (data_mode)
        0:       mem_data = 16'hA000 | {6'b0, s_addr};
        1:       mem_data = INSTR_W'($urandom);
        default: mem_data = data_fix;
      endcase
    end
    if (d_rst) begin
      mq.delete();
      exp_pc = PC_W'(RESET_PC);
      if (mem_busy) mem_stale = 1;
    end else if (d_redir) begin
      mq.delete();
      exp_pc = d_rpc;
      if (mem_busy) mem_stale = 1;
    end

    if (!d_rst && !mem_busy && mq.size() < DEPTH) idle_cnt++;
    else idle_cnt = 0;
    chk("fetch_stall", 32'(idle_cnt > 2), 32'd0);
    if (idle_cnt > 2) idle_cnt = 0;
    cyc++;
  endtask

  task automatic wait_req(input string tag);
    int n0;
    n0 = req_addr.size();
    for (int i = 0; i < 40; i++) begin
      step();
      if (req_addr.size() > n0) break;
    end
    chk(tag, 32'(req_addr.size()), 32'(n0 + 1));
  endtask

  initial begin
    int base;

    // 1 + 2: reset, first fetch timing, then fill with a stalled consumer
    d_rst = 1; d_ready = 0; mem_lat = 1; data_mode = 0;
    step(); step();
    d_rst = 0;
    base = cyc;
    req_cyc.delete(); req_addr.delete(); pop_log.delete();
    first_valid_cyc = -1;
    repeat (20) step();
    chk("t1_first_valid_cyc", 32'(first_valid_cyc - base), 32'd3);
    chk("t1_first_instr", 32'(first_instr), 32'hA000);
    chk("t2_nreq", 32'(req_addr.size()), 32'd4);
    for (int i = 0; i < req_addr.size(); i++) begin
      chk("t1_req_cyc", 32'(req_cyc[i] - base), 32'(1 + 2 * i));
      chk("t1_req_addr", 32'(req_addr[i]), 32'(i));
    end
    chk("t2_full_valid", 32'(instr_valid), 32'd1);
    chk("t2_full_pc", 32'(instr_pc), 32'd0);
    d_ready = 1;
    step();
    d_ready = 0;
    chk("t2_npop", 32'(pop_log.size()), 32'd1);
    if (pop_log.size() > 0) chk("t2_pop_pc", 32'(pop_log[0]), 32'd0);
    repeat (6) step();
    chk("t2_nreq_after_pop", 32'(req_addr.size()), 32'd5);
    if (req_addr.size() > 4) chk("t2_refill_addr", 32'(req_addr[4]), 32'd4);

    // 3: redirect while a request is outstanding; stale 0xDEAD dropped
    d_ready = 1; mem_lat = 4; data_mode = 2; data_fix = 16'hDEAD;
    wait_req("t3_req_seen");
    data_mode = 0;
    d_redir = 1; d_rpc = 10'h120;
    step();
    d_redir = 0;
    step();
    chk("t3_flushed", 32'(instr_valid), 32'd0);
    wait_req("t3_refetch_seen");
    chk("t3_refetch_addr", 32'(req_addr[req_addr.size() - 1]), 32'h120);
    repeat (4) step();
    chk("t3_no_dead", 32'(saw_dead), 32'd0);

    // 4: redirect coincides with ack and a pop
    d_ready = 0; mem_lat = 2;
    repeat (6) step();
    wait_req("t4_req_seen");
    step();
    d_ready = 1; d_redir = 1; d_rpc = 10'h055;
    step();
    chk("t4_valid_at_redirect", 32'(instr_valid), 32'd1);
    d_ready = 0; d_redir = 0;
    step();
    chk("t4_empty", 32'(instr_valid), 32'd0);
    chk("t4_issue", 32'(imem_req), 32'd1);
    chk("t4_issue_addr", 32'(imem_addr), 32'h055);

    // 5: PC wrap
    mem_lat = 1; d_ready = 1;
    d_redir = 1; d_rpc = 10'h3FE;
    step();
    d_redir = 0;
    pop_log.delete();
    repeat (16) step();
    chk("t5_npop", 32'(pop_log.size() >= 4), 32'd1);
    if (pop_log.size() >= 4) begin
      chk("t5_pc0", 32'(pop_log[0]), 32'h3FE);
      chk("t5_pc1", 32'(pop_log[1]), 32'h3FF);
      chk("t5_pc2", 32'(pop_log[2]), 32'h000);
      chk("t5_pc3", 32'(pop_log[3]), 32'h001);
    end

    // 6: reset mid-request with a full queue; stray ack after reset
    d_ready = 0;
    repeat (20) step();
    chk("t6_full", 32'(mq.size()), 32'(DEPTH));
    mem_lat = 10;
    d_ready = 1;
    step();
    d_ready = 0;
    wait_req("t6_req_seen");
    step();
    d_rst = 1;
    step(); step();
    d_rst = 0;
    mem_due = cyc;
    mem_lat = 1;
    base = cyc;
    step();
    chk("t6_req_zero", 32'(imem_req), 32'd0);
    chk("t6_addr_zero", 32'(imem_addr), 32'd0);
    chk("t6_valid_zero", 32'(instr_valid), 32'd0);
    chk("t6_instr_zero", 32'(instr), 32'd0);
    chk("t6_pc_zero", 32'(instr_pc), 32'd0);
    wait_req("t6_post_reset_req");
    chk("t6_req_addr", 32'(req_addr[req_addr.size() - 1]), 32'(RESET_PC));
    chk("t6_req_cyc", 32'(req_cyc[req_cyc.size() - 1] - base), 32'd1);
    repeat (4) step();

    // random traffic
    mem_lat = 0; data_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      d_ready = ($urandom_range(0, 9) < 7);
      d_redir = ($urandom_range(0, 19) == 0);
      d_rpc   = ($urandom_range(0, 3) == 0) ? PC_W'(10'h3FC + $urandom_range(0, 3))
                                            : PC_W'($urandom);
      step();
    end
    d_redir = 0; d_ready = 1;
    repeat (20) step();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
